// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I datapath width, ALU operation codes and operand select codes.
package rv32i_pkg;
    localparam int XLEN = 32;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SRL  = 4'd3,
        ALU_SRA  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_AND  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_XOR  = 4'd9
    } alu_op_e;
    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;
    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;
endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// fwd_mux: resolves one source register against EX, MEM and WB results in that priority.
module fwd_mux #(
    parameter int W = 32
) (
    input  logic [4:0]   i_rs_addr,
    input  logic [W-1:0] i_rf_data,
    input  logic         i_ex_en,
    input  logic [4:0]   i_ex_rd,
    input  logic [W-1:0] i_ex_data,
    input  logic         i_mem_en,
    input  logic [4:0]   i_mem_rd,
    input  logic [W-1:0] i_mem_data,
    input  logic         i_wb_en,
    input  logic [4:0]   i_wb_rd,
    input  logic [W-1:0] i_wb_data,
    output logic [W-1:0] o_data
);
    assign o_data = (i_rs_addr == 5'd0)                     ? '0 :
                    (i_ex_en  && i_ex_rd  == i_rs_addr)     ? i_ex_data :
                    (i_mem_en && i_mem_rd == i_rs_addr)     ? i_mem_data :
                    (i_wb_en  && i_wb_rd  == i_rs_addr)     ? i_wb_data : i_rf_data;
endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register with operand forwarding, load-use bubble insertion
// and registered ALU operands.
module ex_operand_stage #(
    parameter int XLEN       = 32,
    parameter int ALU_CTRL_W = 4
) (
    input  logic                  pll_1_200MHz,
    input  logic                  pll_1_locked,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [4:0]            id_rs1_addr,
    input  logic [4:0]            id_rs2_addr,
    input  logic [4:0]            id_rd_addr,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [1:0]            id_src_a_sel,
    input  logic [1:0]            id_src_b_sel,
    input  logic [ALU_CTRL_W-1:0] id_alu_control,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic [XLEN-1:0]       alu_result,
    input  logic                  mem_fwd_valid,
    input  logic [4:0]            mem_fwd_rd,
    input  logic [XLEN-1:0]       mem_fwd_data,
    input  logic                  wb_fwd_valid,
    input  logic [4:0]            wb_fwd_rd,
    input  logic [XLEN-1:0]       wb_fwd_data,
    input  logic                  ex_stall,
    input  logic                  flush,
    output logic [XLEN-1:0]       operand_a,
    output logic [XLEN-1:0]       operand_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_store_data,
    output logic [4:0]            ex_rd_addr,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write
);
    import rv32i_pkg::*;

    logic                  r_valid, r_reg_write, r_mem_read, r_mem_write;
    logic [XLEN-1:0]       r_op_a, r_op_b, r_pc, r_store_data;
    logic [ALU_CTRL_W-1:0] r_alu_control;
    logic [4:0]            r_rd_addr;
    logic                  w_ex_fwd_en, w_load_use, w_capture;
    logic [XLEN-1:0]       w_rs1, w_rs2, w_op_a, w_op_b;

    // A load in EX has no value yet, so it is never a forward source; it stalls instead.
    assign w_ex_fwd_en = r_valid & r_reg_write & ~r_mem_read;
    assign w_load_use  = r_valid & r_mem_read & (r_rd_addr != 5'd0) &
                         ((id_uses_rs1 & (id_rs1_addr == r_rd_addr)) |
                          (id_uses_rs2 & (id_rs2_addr == r_rd_addr)));
    assign id_ready    = ~ex_stall & ~w_load_use;
    assign w_capture   = id_valid & ~w_load_use;

    fwd_mux #(.W(XLEN)) u_fwd_rs1 (
        .i_rs_addr(id_rs1_addr), .i_rf_data(id_rs1_data),
        .i_ex_en(w_ex_fwd_en), .i_ex_rd(r_rd_addr), .i_ex_data(alu_result),
        .i_mem_en(mem_fwd_valid), .i_mem_rd(mem_fwd_rd), .i_mem_data(mem_fwd_data),
        .i_wb_en(wb_fwd_valid), .i_wb_rd(wb_fwd_rd), .i_wb_data(wb_fwd_data),
        .o_data(w_rs1)
    );

    fwd_mux #(.W(XLEN)) u_fwd_rs2 (
        .i_rs_addr(id_rs2_addr), .i_rf_data(id_rs2_data),
        .i_ex_en(w_ex_fwd_en), .i_ex_rd(r_rd_addr), .i_ex_data(alu_result),
        .i_mem_en(mem_fwd_valid), .i_mem_rd(mem_fwd_rd), .i_mem_data(mem_fwd_data),
        .i_wb_en(wb_fwd_valid), .i_wb_rd(wb_fwd_rd), .i_wb_data(wb_fwd_data),
        .o_data(w_rs2)
    );

    assign w_op_a = (id_src_a_sel == SRC_A_RS1) ? w_rs1 :
                    (id_src_a_sel == SRC_A_PC)  ? id_pc : '0;
    assign w_op_b = (id_src_b_sel == SRC_B_RS2)  ? w_rs2 :
                    (id_src_b_sel == SRC_B_IMM)  ? id_imm :
                    (id_src_b_sel == SRC_B_FOUR) ? XLEN'(4) : '0;

    // Datapath registers load on every non-stalled cycle; bubbles only clear valid and flags.
    always_ff @(posedge pll_1_200MHz or negedge pll_1_locked) begin
        if (!pll_1_locked) begin
            r_valid       <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_pc          <= '0;
            r_store_data  <= '0;
            r_rd_addr     <= '0;
            r_alu_control <= ALU_CTRL_W'(ALU_ADD);
        end else if (flush) begin
            r_valid       <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
        end else if (!ex_stall) begin
            r_valid       <= w_capture;
            r_reg_write   <= w_capture & id_reg_write;
            r_mem_read    <= w_capture & id_mem_read;
            r_mem_write   <= w_capture & id_mem_write;
            r_op_a        <= w_op_a;
            r_op_b        <= w_op_b;
            r_pc          <= id_pc;
            r_store_data  <= w_rs2;
            r_rd_addr     <= id_rd_addr;
            r_alu_control <= id_alu_control;
        end
    end

    assign ex_valid      = r_valid;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign operand_a     = r_op_a;
    assign operand_b     = r_op_b;
    assign ex_pc         = r_pc;
    assign ex_store_data = r_store_data;
    assign ex_rd_addr    = r_rd_addr;
    assign alu_control   = r_alu_control;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed hazard scenarios plus randomized traffic, checked against
// a behavioural model of the ID/EX stage.
module tb_ex_operand_stage;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        id_valid, id_ready, id_uses_rs1, id_uses_rs2;
    logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data, alu_result, mem_fwd_data, wb_fwd_data;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, mem_fwd_rd, wb_fwd_rd, ex_rd_addr;
    logic [1:0]  id_src_a_sel, id_src_b_sel;
    logic [3:0]  id_alu_control, alu_control;
    logic        id_reg_write, id_mem_read, id_mem_write, mem_fwd_valid, wb_fwd_valid;
    logic        ex_stall, flush, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [31:0] operand_a, operand_b, ex_pc, ex_store_data;

    int checks = 0, errors = 0;

    // Model of what the EX stage should hold
    logic        m_valid, m_rw, m_mr, m_mw;
    logic [4:0]  m_rd;
    logic [3:0]  m_ctl;
    logic [31:0] m_a, m_b, m_pc, m_sd;

    always #5 clk = ~clk;

    ex_operand_stage #(.XLEN(32), .ALU_CTRL_W(4)) dut (
        .pll_1_200MHz(clk), .pll_1_locked(rst_n),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_src_a_sel(id_src_a_sel), .id_src_b_sel(id_src_b_sel),
        .id_alu_control(id_alu_control), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .alu_result(alu_result),
        .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .ex_stall(ex_stall), .flush(flush),
        .operand_a(operand_a), .operand_b(operand_b), .alu_control(alu_control),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_store_data(ex_store_data),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Newest producer wins; x0 is hardwired zero
    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
        logic        en[3];
        logic [4:0]  rd[3];
        logic [31:0] d[3];
        en = '{m_valid && m_rw && !m_mr, mem_fwd_valid, wb_fwd_valid};
        rd = '{m_rd, mem_fwd_rd, wb_fwd_rd};
        d  = '{alu_result, mem_fwd_data, wb_fwd_data};
        if (rs == 5'd0) return 32'd0;
        for (int i = 0; i < 3; i++) if (en[i] && rd[i] == rs) return d[i];
        return rf;
    endfunction

    task automatic compare_all();
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
        chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m_rw});
        chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m_mr});
        chk("ex_mem_write", {31'd0, ex_mem_write}, {31'd0, m_mw});
        if (m_valid) begin
            chk("operand_a", operand_a, m_a);
            chk("operand_b", operand_b, m_b);
            chk("alu_control", {28'd0, alu_control}, {28'd0, m_ctl});
            chk("ex_pc", ex_pc, m_pc);
            chk("ex_store_data", ex_store_data, m_sd);
            chk("ex_rd_addr", {27'd0, ex_rd_addr}, {27'd0, m_rd});
        end
    endtask

    task automatic step();
        logic        lu, cap;
        logic [31:0] sa[4], sb[4];
        #1;
        lu = m_valid && m_mr && m_rd != 5'd0 &&
             ((id_uses_rs1 && id_rs1_addr == m_rd) || (id_uses_rs2 && id_rs2_addr == m_rd));
        chk("id_ready", {31'd0, id_ready}, {31'd0, !ex_stall && !lu});
        sa = '{fwd(id_rs1_addr, id_rs1_data), id_pc, 32'd0, 32'd0};
        sb = '{fwd(id_rs2_addr, id_rs2_data), id_imm, 32'd4, 32'd0};
        if (flush) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
        end else if (!ex_stall) begin
            cap = id_valid && !lu;
            m_valid = cap;
            m_rw = cap && id_reg_write;
            m_mr = cap && id_mem_read;
            m_mw = cap && id_mem_write;
            if (cap) begin
                m_a = sa[id_src_a_sel]; m_b = sb[id_src_b_sel];
                m_sd = sb[0]; m_pc = id_pc; m_rd = id_rd_addr; m_ctl = id_alu_control;
            end
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_src_a_sel = 0; id_src_b_sel = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_alu_control = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
        id_pc = 0; id_imm = 0; id_rs1_data = 0; id_rs2_data = 0; alu_result = 0;
        mem_fwd_valid = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
        wb_fwd_valid = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
        ex_stall = 0; flush = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [1:0] sa, input logic [1:0] sb,
                         input logic rw, input logic mr, input logic [31:0] imm);
        id_valid = 1; id_rd_addr = rd; id_rs1_addr = rs1; id_rs2_addr = rs2;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_src_a_sel = sa; id_src_b_sel = sb;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = 0; id_imm = imm;
        id_alu_control = 4'($urandom_range(0, 9));
        id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
    endtask

    task automatic check_reset_values();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
        #1;
        compare_all();
        chk("rst_operand_a", operand_a, 32'd0);
        chk("rst_operand_b", operand_b, 32'd0);
        chk("rst_alu_control", {28'd0, alu_control}, 32'd0);
        chk("rst_ex_pc", ex_pc, 32'd0);
        chk("rst_store_data", ex_store_data, 32'd0);
        chk("rst_rd_addr", {27'd0, ex_rd_addr}, 32'd0);
    endtask

    initial begin
        idle();
        check_reset_values();
        @(negedge clk);
        rst_n = 1;

        // EX forward
        issue(5, 1, 2, 1, 1, 0, 0, 1, 0, 0); step();
        issue(7, 5, 0, 1, 0, 0, 1, 1, 0, 32'd3); alu_result = 32'h10; step();
        chk("exfwd_a", operand_a, 32'h10);
        chk("exfwd_b", operand_b, 32'd3);

        // Priority EX > MEM > WB on x7
        issue(0, 7, 0, 1, 0, 0, 1, 0, 0, 0);
        alu_result = 32'hA; mem_fwd_valid = 1; mem_fwd_rd = 7; mem_fwd_data = 32'hB;
        wb_fwd_valid = 1; wb_fwd_rd = 7; wb_fwd_data = 32'hC; step();
        chk("prio_ex", operand_a, 32'hA);
        issue(0, 7, 0, 1, 0, 0, 1, 0, 0, 0); step();
        chk("prio_mem", operand_a, 32'hB);
        mem_fwd_valid = 0; issue(0, 7, 0, 1, 0, 0, 1, 0, 0, 0); step();
        chk("prio_wb", operand_a, 32'hC);
        wb_fwd_valid = 0;

        // Load-use: LW x3 then ADD using x3
        issue(3, 1, 0, 1, 0, 0, 1, 1, 1, 32'd8); step();
        issue(4, 1, 3, 1, 1, 0, 0, 1, 0, 0); #1;
        chk("lu_id_ready", {31'd0, id_ready}, 32'd0);
        step();
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        mem_fwd_valid = 1; mem_fwd_rd = 3; mem_fwd_data = 32'h55; step();
        chk("lu_fwd_b", operand_b, 32'h55);
        chk("lu_valid", {31'd0, ex_valid}, 32'd1);
        mem_fwd_valid = 0;

        // x0 is never forwarded and never causes a load-use stall
        issue(0, 1, 0, 1, 0, 0, 1, 1, 1, 0); step();
        issue(9, 0, 0, 1, 0, 0, 1, 1, 0, 0); alu_result = 32'hFF; #1;
        chk("x0_ready", {31'd0, id_ready}, 32'd1);
        step();
        chk("x0_a", operand_a, 32'd0);

        // Flush wins over stall; stall alone holds for three cycles
        issue(2, 1, 1, 1, 1, 0, 0, 1, 0, 0); flush = 1; ex_stall = 1; step();
        chk("flush_stall", {31'd0, ex_valid}, 32'd0);
        flush = 0; ex_stall = 0; issue(2, 1, 1, 1, 1, 1, 2, 1, 0, 0); step();
        ex_stall = 1;
        for (int i = 0; i < 3; i++) begin
            issue(6, 2, 2, 1, 1, 0, 1, 1, 0, $urandom);
            step();
        end
        ex_stall = 0;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            id_valid = $urandom_range(0, 3) != 0;
            id_rs1_addr = 5'($urandom_range(0, 3)); id_rs2_addr = 5'($urandom_range(0, 3));
            id_rd_addr = 5'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
            id_src_a_sel = 2'($urandom); id_src_b_sel = 2'($urandom);
            id_alu_control = 4'($urandom_range(0, 9));
            id_reg_write = 1'($urandom); id_mem_read = $urandom_range(0, 2) == 0;
            id_mem_write = 1'($urandom);
            id_pc = $urandom; id_imm = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
            alu_result = $urandom;
            mem_fwd_valid = 1'($urandom); mem_fwd_rd = 5'($urandom_range(0, 3)); mem_fwd_data = $urandom;
            wb_fwd_valid = 1'($urandom); wb_fwd_rd = 5'($urandom_range(0, 3)); wb_fwd_data = $urandom;
            ex_stall = $urandom_range(0, 4) == 0;
            flush = $urandom_range(0, 9) == 0;
            step();
        end

        // Asynchronous reset while holding a valid instruction
        idle(); issue(8, 1, 2, 1, 1, 0, 0, 1, 0, 0); step();
        chk("pre_reset_valid", {31'd0, ex_valid}, 32'd1);
        @(negedge clk);
        #2 rst_n = 0;
        check_reset_values();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
